acl_poll_sequencer: RTL and testbench

Sequences periodic accelerometer sampling over a shared byte-oriented SPI master.
- After enable, issues a one-time register configuration burst.
- Then, on every internal sample tick, reads six data bytes and publishes X/Y/Z as 16-bit words with a valid strobe.
- Replaces free-running divided-clock sampling with a single-clock-domain tick enable.

---
 rtl/acl_poll_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_acl_poll_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acl_poll_sequencer.sv
// Accelerometer poll sequencer: one-time config burst over a byte SPI master, then 6-byte X/Y/Z reads per sample tick.
// Build option: define ACL_TIMEOUT_EN to add the spi_done watchdog (timeout_err is tied low otherwise).
//
// state       | meaning
// S_IDLE      | disabled, no frame in flight
// S_CFG_ISSUE | waiting for spi_busy=0 to launch config frame idx
// S_CFG_WAIT  | config frame in flight
// S_WAIT_TICK | configured, waiting for the sample tick
// S_RD_ISSUE  | waiting for spi_busy=0 to launch read of data byte idx
// S_RD_WAIT   | read frame in flight
// S_UPDATE    | acc_* just loaded, data_valid high
module acl_poll_sequencer #(
   parameter int unsigned TICK_END    = 10000000,
   parameter logic [15:0] CFG0_WORD   = 16'h2D08,
   parameter logic [15:0] CFG1_WORD   = 16'h3100,
   parameter logic [7:0]  RD_BASE     = 8'h32,
   parameter int unsigned TIMEOUT_CYC = 4095
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        en,
   input  logic        spi_busy,
   input  logic        spi_done,
   input  logic [7:0]  spi_rx,
   output logic        spi_start,
   output logic [15:0] spi_tx,
   output logic [15:0] acc_x,
   output logic [15:0] acc_y,
   output logic [15:0] acc_z,
   output logic        data_valid,
   output logic        cfg_done,
   output logic        overrun,
   output logic        active,
   output logic        timeout_err
);

   localparam int unsigned TW = (TICK_END > 0) ? $clog2(TICK_END + 1) : 1;
   localparam logic [TW-1:0] TICK_TC = TW'(TICK_END);

   typedef enum logic [2:0] {
      S_IDLE, S_CFG_ISSUE, S_CFG_WAIT, S_WAIT_TICK, S_RD_ISSUE, S_RD_WAIT, S_UPDATE
   } state_t;

   state_t        state, state_nxt;
   logic [2:0]    idx, idx_nxt;
   logic [TW-1:0] tick_cnt;
   logic          tick_run, tick;
   logic          wd_fire, done_ok;
   logic [7:0]    shadow [5];
   logic [7:0]    rd_addr;
   logic [15:0]   cfg_frame, rd_frame;

   assign tick_run = en && cfg_done;
   assign tick     = tick_run && (tick_cnt == TICK_TC);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                   tick_cnt <= '0;
      else if (!tick_run || tick) tick_cnt <= '0;
      else                       tick_cnt <= tick_cnt + 1'b1;
   end

`ifdef ACL_TIMEOUT_EN
   localparam int unsigned WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [WW-1:0] WD_LOAD = WW'(TIMEOUT_CYC - 1);

   logic          in_wait;
   logic [WW-1:0] wd_cnt;

   assign in_wait = (state == S_CFG_WAIT) || (state == S_RD_WAIT);
   assign wd_fire = in_wait && !spi_done && (wd_cnt == '0);

   // Reloaded in every non-WAIT cycle so each frame gets a full window.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)              wd_cnt <= '0;
      else if (!in_wait)    wd_cnt <= WD_LOAD;
      else if (wd_cnt != '0) wd_cnt <= wd_cnt - 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)          timeout_err <= 1'b0;
      else if (wd_fire) timeout_err <= 1'b1;
   end
`else
   assign wd_fire     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign done_ok   = spi_done && !wd_fire;
   assign cfg_frame = idx[0] ? CFG1_WORD : CFG0_WORD;
   assign rd_addr   = RD_BASE + {5'd0, idx};
   assign rd_frame  = {8'h80 | rd_addr, 8'h00};

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      spi_start = 1'b0;
      spi_tx    = '0;
      case (state)
         S_IDLE: begin
            if (en) begin
               idx_nxt   = '0;
               state_nxt = cfg_done ? S_WAIT_TICK : S_CFG_ISSUE;
            end
         end
         S_CFG_ISSUE: begin
            spi_tx = cfg_frame;
            if (!en) state_nxt = S_IDLE;
            else if (!spi_busy) begin
               spi_start = 1'b1;
               state_nxt = S_CFG_WAIT;
            end
         end
         S_CFG_WAIT: begin
            spi_tx = cfg_frame;
            if (wd_fire) state_nxt = S_IDLE;
            else if (spi_done) begin
               if (!en)               state_nxt = S_IDLE;
               else if (idx == 3'd1) state_nxt = S_WAIT_TICK;
               else begin
                  idx_nxt   = 3'd1;
                  state_nxt = S_CFG_ISSUE;
               end
            end
         end
         S_WAIT_TICK: begin
            if (!en) state_nxt = S_IDLE;
            else if (tick) begin
               idx_nxt   = '0;
               state_nxt = S_RD_ISSUE;
            end
         end
         S_RD_ISSUE: begin
            spi_tx = rd_frame;
            if (!en) state_nxt = S_IDLE;
            else if (!spi_busy) begin
               spi_start = 1'b1;
               state_nxt = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            spi_tx = rd_frame;
            if (wd_fire) state_nxt = S_IDLE;
            else if (spi_done) begin
               if (!en)               state_nxt = S_IDLE;
               else if (idx == 3'd5) state_nxt = S_UPDATE;
               else begin
                  idx_nxt   = idx + 3'd1;
                  state_nxt = S_RD_ISSUE;
               end
            end
         end
         S_UPDATE: state_nxt = S_WAIT_TICK;
         default:  state_nxt = S_IDLE;
      endcase
   end

   assign data_valid = (state == S_UPDATE);
   assign active     = (state != S_IDLE);

   // acc_* load on the 6th done so they change exactly in the data_valid cycle; byte 5 comes straight from spi_rx.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= S_IDLE;
         idx      <= '0;
         cfg_done <= 1'b0;
         overrun  <= 1'b0;
         acc_x    <= '0;
         acc_y    <= '0;
         acc_z    <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         if ((state == S_CFG_WAIT) && done_ok && (idx == 3'd1))
            cfg_done <= 1'b1;
         if (tick && ((state == S_RD_ISSUE) || (state == S_RD_WAIT) || (state == S_UPDATE)))
            overrun <= 1'b1;
         if ((state == S_RD_WAIT) && (state_nxt == S_UPDATE)) begin
            acc_x <= {shadow[1], shadow[0]};
            acc_y <= {shadow[3], shadow[2]};
            acc_z <= {spi_rx, shadow[4]};
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int k = 0; k < 5; k++) shadow[k] <= '0;
      end else if ((state == S_RD_WAIT) && done_ok && (idx < 3'd5)) begin
         shadow[idx] <= spi_rx;
      end
   end

endmodule

// File: tb/tb_acl_poll_sequencer.sv
// Bench for acl_poll_sequencer: SPI slave model with frame/sample scoreboards; tick period shortened to 40 cycles.
module tb_acl_poll_sequencer;

   localparam int TE = 39;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        en = 1'b0;
   logic        m_busy = 1'b0, hold_busy = 1'b0;
   logic        m_done = 1'b0, stray_done = 1'b0;
   logic [7:0]  m_rx = 8'h00, stray_rx = 8'h00;
   logic        spi_busy, spi_done;
   logic [7:0]  spi_rx;
   logic        spi_start, data_valid, cfg_done, overrun, active, timeout_err;
   logic [15:0] spi_tx, acc_x, acc_y, acc_z;

   assign spi_busy = m_busy | hold_busy;
   assign spi_done = m_done | stray_done;
   assign spi_rx   = m_done ? m_rx : stray_rx;

   acl_poll_sequencer #(.TICK_END(TE)) dut (
      .CLK(CLK), .RST(RST), .en(en),
      .spi_busy(spi_busy), .spi_done(spi_done), .spi_rx(spi_rx),
      .spi_start(spi_start), .spi_tx(spi_tx),
      .acc_x(acc_x), .acc_y(acc_y), .acc_z(acc_z),
      .data_valid(data_valid), .cfg_done(cfg_done), .overrun(overrun),
      .active(active), .timeout_err(timeout_err)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [15:0] exp_tx[$];
   logic [47:0] exp_acc[$];
   int          lat = 3;
   int          rem = 0;
   int          nstart = 0;
   int          ndv = 0;
   int          burst_frames = 0;
   logic [7:0]  byte_base = 8'h11;
   logic [7:0]  cur_byte = 8'h00;
   logic        start_seen;

   function automatic logic [47:0] acc_of(input logic [7:0] b);
      return {b + 8'd1, b, b + 8'd3, b + 8'd2, b + 8'd5, b + 8'd4};
   endfunction

   // SPI slave: one frame at a time, done pulse lat cycles after accepting start
   initial begin
      forever begin
         @(negedge CLK);
         start_seen = 1'b0;
         if (!RST && spi_start) begin
            start_seen = 1'b1;
            nstart++;
            check("start_gated", 64'(spi_busy), 64'(0));
            check("one_outstanding", 64'(rem != 0), 64'(0));
            check("tx_avail", 64'(exp_tx.size() > 0), 64'(1));
            if (exp_tx.size() > 0) check("spi_tx", 64'(spi_tx), 64'(exp_tx.pop_front()));
            if (spi_tx[15:8] == 8'hB2) burst_frames = 1;
            else if (spi_tx[15])       burst_frames++;
            cur_byte = byte_base + 8'(burst_frames - 1);
         end
         @(posedge CLK);
         #1;
         m_done = 1'b0;
         if (RST) begin
            m_busy = 1'b0;
            rem    = 0;
         end else if (start_seen) begin
            m_busy = 1'b1;
            rem    = lat;
         end else if (rem > 0) begin
            rem--;
            if (rem == 0) begin
               m_done = 1'b1;
               m_rx   = cur_byte;
               m_busy = 1'b0;
            end
         end
      end
   end

   logic [47:0] prev_acc = '0;
   logic        dv_prev = 1'b0;

   initial begin
      forever begin
         @(negedge CLK);
         if (RST) begin
            prev_acc = '0;
            dv_prev  = 1'b0;
         end else begin
            if (data_valid) begin
               ndv++;
               check("dv_width", 64'(dv_prev), 64'(0));
               check("frames_per_dv", 64'(burst_frames), 64'(6));
               check("acc_avail", 64'(exp_acc.size() > 0), 64'(1));
               if (exp_acc.size() > 0) check("acc_xyz", 64'({acc_x, acc_y, acc_z}), 64'(exp_acc.pop_front()));
            end else begin
               check("acc_stable", 64'({acc_x, acc_y, acc_z}), 64'(prev_acc));
            end
            prev_acc = {acc_x, acc_y, acc_z};
            dv_prev  = data_valid;
         end
      end
   end

   task automatic check_cleared(input string tag);
      check({tag, "_start"},   64'(spi_start),   64'(0));
      check({tag, "_tx"},      64'(spi_tx),      64'(0));
      check({tag, "_acc"},     64'({acc_x, acc_y, acc_z}), 64'(0));
      check({tag, "_dv"},      64'(data_valid),  64'(0));
      check({tag, "_cfgdone"}, 64'(cfg_done),    64'(0));
      check({tag, "_overrun"}, 64'(overrun),     64'(0));
      check({tag, "_active"},  64'(active),      64'(0));
      check({tag, "_tmo"},     64'(timeout_err), 64'(0));
   endtask

   task automatic wait_dv(input int budget);
      int target;
      int n;
      target = ndv + 1;
      n = 0;
      while (ndv < target && n < budget) begin
         @(posedge CLK);
         n++;
      end
      check("dv_arrived", 64'(ndv >= target), 64'(1));
      #1;
   endtask

   task automatic wait_starts(input int target, input int budget);
      int n;
      n = 0;
      while (nstart < target && n < budget) begin
         @(posedge CLK);
         n++;
      end
      check("start_arrived", 64'(nstart >= target), 64'(1));
      #1;
   endtask

   task automatic push_reads(input logic [7:0] b, input int count);
      for (int k = 0; k < count; k++) exp_tx.push_back({8'hB2 + 8'(k), 8'h00});
      byte_base = b;
   endtask

   initial begin
      int n, n0, dv0;
      #2;
      check_cleared("reset");
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;

      // config burst then first sample
      exp_tx.push_back(16'h2D08);
      exp_tx.push_back(16'h3100);
      push_reads(8'h11, 6);
      exp_acc.push_back(48'h1211_1413_1615);
      en = 1'b1;
      n = 0;
      while (!cfg_done && n < 500) begin
         @(negedge CLK);
         n++;
      end
      check("cfg_done", 64'(cfg_done), 64'(1));
      check("starts_at_cfg", 64'(nstart), 64'(2));
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!spi_start && n < 200);
      check("tick_gap", 64'(n), 64'(TE + 1));
      wait_dv(200);
      en = 1'b0;
      check("overrun_clear", 64'(overrun), 64'(0));
      repeat (2) @(posedge CLK);
      #1;
      check("idle_after_dv", 64'(active), 64'(0));
      check("tx_drained1", 64'(exp_tx.size()), 64'(0));

      // busy gating plus a stray done while waiting for the tick
      push_reads(8'h21, 6);
      exp_acc.push_back(acc_of(8'h21));
      hold_busy = 1'b1;
      en = 1'b1;
      n0 = nstart;
      repeat (5) @(posedge CLK);
      #1 stray_done = 1'b1;
      stray_rx = 8'hEE;
      @(posedge CLK);
      #1 stray_done = 1'b0;
      repeat (39) @(posedge CLK);
      #1;
      check("no_start_while_busy", 64'(nstart), 64'(n0));
      hold_busy = 1'b0;
      @(negedge CLK);
      check("start_after_busy", 64'(spi_start), 64'(1));
      @(negedge CLK);
      check("start_width", 64'(spi_start), 64'(0));
      wait_dv(200);
      en = 1'b0;
      check("tx_drained2", 64'(exp_tx.size()), 64'(0));

      // slow SPI: tick lands mid-burst
      repeat (2) @(posedge CLK);
      #1 lat = 10;
      push_reads(8'h31, 6);
      exp_acc.push_back(acc_of(8'h31));
      en = 1'b1;
      wait_dv(400);
      en = 1'b0;
      check("overrun_set", 64'(overrun), 64'(1));
      check("tx_drained3", 64'(exp_tx.size()), 64'(0));

      // en drops after the 3rd read start
      repeat (2) @(posedge CLK);
      #1 lat = 3;
      push_reads(8'h41, 3);
      n0 = nstart;
      dv0 = ndv;
      en = 1'b1;
      wait_starts(n0 + 3, 300);
      en = 1'b0;
      repeat (20) @(posedge CLK);
      #1;
      check("drop_idle", 64'(active), 64'(0));
      check("drop_no_dv", 64'(ndv), 64'(dv0));
      check("drop_frames", 64'(nstart), 64'(n0 + 3));
      check("drop_cfg_kept", 64'(cfg_done), 64'(1));
      check("tx_drained4", 64'(exp_tx.size()), 64'(0));

      // re-enable: no config frames, burst restarts at 0x32
      push_reads(8'h51, 6);
      exp_acc.push_back(acc_of(8'h51));
      en = 1'b1;
      wait_dv(200);
      en = 1'b0;
      check("tx_drained5", 64'(exp_tx.size()), 64'(0));

      // async reset with a frame in flight
      repeat (2) @(posedge CLK);
      #1 lat = 10;
      push_reads(8'h61, 1);
      n0 = nstart;
      en = 1'b1;
      wait_starts(n0 + 1, 200);
      @(posedge CLK);
      #3 RST = 1'b1;
      en = 1'b0;
      #1;
      check_cleared("async_rst");
      @(posedge CLK);
      #1 RST = 1'b0;
      exp_tx.delete();
      exp_acc.delete();
      repeat (5) @(posedge CLK);
      #1;
      check("post_rst_idle", 64'(active), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
